// File: rtl/mca_control_snapshot.sv
// Shifts per-cycle control vectors into a K-deep history, decimates by OSR and
// freezes a snapshot onto S_matrix for the MCA adder, holding it MCA_LATENCY cycles.
module mca_control_snapshot #(
    parameter int K           = 256,
    parameter int N           = 8,
    parameter int OSR         = 8,
    parameter int MCA_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    input  logic [N-1:0]          s_in,
    input  logic                  clear_overrun,
    output logic [K-1:0][N-1:0]   S_matrix,
    output logic                  start,
    output logic                  done,
    output logic                  warm,
    output logic                  overrun
);
    localparam int FW = $clog2(K + 1);
    localparam int DW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int BW = $clog2(MCA_LATENCY + 1);

    localparam logic [FW-1:0] FILL_FULL = FW'(K);
    localparam logic [FW-1:0] FILL_LAST = FW'(K - 1);
    localparam logic [DW-1:0] DEC_MAX   = DW'(OSR - 1);
    localparam logic [BW-1:0] BUSY_INIT = BW'(MCA_LATENCY);

    logic [K-1:0][N-1:0] hist_q, hist_d;
    logic [K-1:0][N-1:0] snap_q, snap_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [DW-1:0]       dec_q, dec_d;
    logic [BW-1:0]       busy_q, busy_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                warm_q, warm_d;
    logic                ovr_q, ovr_d;
    logic                full_next;
    logic                evt;

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        dec_d     = dec_q;
        full_next = 1'b0;
        evt       = 1'b0;
        if (s_valid) begin
            hist_d    = {hist_q[K-2:0], s_in};
            full_next = (fill_q >= FILL_LAST);
            if (fill_q != FILL_FULL)
                fill_d = fill_q + 1'b1;
            // dec_cnt only starts running once the history is about to be full,
            // so the first event lands on the K-th sample.
            if (full_next)
                dec_d = (dec_q == DEC_MAX) ? '0 : dec_q + 1'b1;
            evt = full_next && (dec_q == '0);
        end

        snap_d  = snap_q;
        start_d = 1'b0;
        busy_d  = (busy_q != '0) ? busy_q - 1'b1 : '0;
        ovr_d   = clear_overrun ? 1'b0 : ovr_q;
        if (evt) begin
            // A window still counting down (even its last cycle) blocks the snapshot.
            if (busy_q == '0) begin
                snap_d  = hist_d;
                start_d = 1'b1;
                busy_d  = BUSY_INIT;
            end else begin
                ovr_d = 1'b1;
            end
        end
        done_d = (busy_q == BW'(1));
        warm_d = (fill_d == FILL_FULL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_q  <= '0;
            snap_q  <= '0;
            fill_q  <= '0;
            dec_q   <= '0;
            busy_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            warm_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            snap_q  <= snap_d;
            fill_q  <= fill_d;
            dec_q   <= dec_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            done_q  <= done_d;
            warm_q  <= warm_d;
            ovr_q   <= ovr_d;
        end
    end

    assign S_matrix = snap_q;
    assign start    = start_q;
    assign done     = done_q;
    assign warm     = warm_q;
    assign overrun  = ovr_q;
endmodule
